cart_mem_responder: RTL and testbench
=====================================

CART_MEM_RESPONDER -- requirements
Module: cart_mem_responder

Interface
REQ-001 SHALL have parameter BSRAM_BASE, default 25'h1000000: backing-memory base address of the BSRAM window.
REQ-002 SHALL have parameter ROM_WIDTH, default 24: ROM address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: mclk input 1 is the system master clock; rst_n input 1 is the asynchronous active-low reset.
REQ-004 SHALL have ports rom_addr input 24 (ROM byte address), rom_d input 16 (ROM write data), rom_ce_n input 1, rom_oe_n input 1, rom_we_n input 1, rom_word input 1 (16-bit access).
REQ-005 SHALL have port rom_q output 16: ROM read data.
REQ-006 SHALL have ports bsram_addr input 20, bsram_d input 8, bsram_ce_n input 1, bsram_oe_n input 1, bsram_we_n input 1.
REQ-007 SHALL have port bsram_q output 8: BSRAM read data.
REQ-008 SHALL have backing-memory ports mem_req output 1, mem_we output 1, mem_addr output 25, mem_be output 2, mem_wdata output 16, mem_ack input 1 (one-cycle completion pulse), mem_rdata input 16 (valid with mem_ack).
REQ-009 SHALL have port busy output 1: a request is in flight or pending.

Function
REQ-010 SHALL detect a ROM access start when (!rom_ce_n & (!rom_oe_n | write-enabled !rom_we_n)) rises, or when rom_addr changes while that condition holds; BSRAM start detection SHALL be identical on its own signals.
REQ-011 SHALL latch address, data, word flag and direction at detection into a one-deep pending slot per port; a newer detection SHALL overwrite an unserviced slot.
REQ-012 SHALL use FSM states IDLE, ROM_ACC, BS_ACC: IDLE->ROM_ACC when the ROM slot is pending, else IDLE->BS_ACC when the BSRAM slot is pending; ROM takes priority on simultaneous pending.
REQ-013 SHALL leave X_ACC for IDLE on mem_ack and clear that port's slot, unless a detection on the same port occurs in the ack cycle, in which case the slot SHALL stay pending.
REQ-014 SHALL register mem_req on the cycle after entering X_ACC, hold it high with mem_addr/mem_we/mem_be/mem_wdata stable until mem_ack, and drop it in the ack cycle.
REQ-015 SHALL form mem_addr as {1'b0, rom_addr} for ROM and as BSRAM_BASE | bsram_addr for BSRAM.
REQ-016 SHALL drive mem_be as 2'b11 for a word access, 2'b10 for a byte access with addr[0]=1, and 2'b01 for a byte access with addr[0]=0; BSRAM accesses are always byte accesses.
REQ-017 SHALL drive mem_wdata as rom_d for a ROM word write, and as the data byte replicated to both halves for a byte write.
REQ-018 SHALL, on a ROM read ack, load rom_q with mem_rdata for a word access, or with the selected byte replicated to both halves for a byte access.
REQ-019 SHALL, on a BSRAM read ack, load bsram_q with the selected byte; rom_q and bsram_q SHALL otherwise hold their values.
REQ-020 SHALL ignore mem_ack while mem_req is low.
REQ-021 SHALL drive busy = (state != IDLE) | either slot pending.
REQ-022 SHALL have a minimum latency of 3 mclk from detection to updated rom_q/bsram_q with zero-wait mem_ack.

Reset
REQ-023 SHALL, while rst_n=0, force state IDLE, both slots cleared, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, rom_q=0, bsram_q=0, busy=0.
REQ-024 SHALL, on reset asserted mid-access, abort the access immediately and discard any later mem_ack.

Configuration
REQ-025 SHALL, with CART_ROM_WRITE_EN defined, honour rom_we_n as a ROM write strobe (mem_we=1), as used for flash-cartridge writes.
REQ-026 SHALL, without CART_ROM_WRITE_EN, ignore rom_we_n and rom_d, issue all ROM accesses as reads, and keep BSRAM writes unaffected.

Structure
REQ-027 SHALL place the state enum, the port-select enum and the BSRAM_BASE default in package cart_mem_pkg.
REQ-028 SHALL implement start detection (edge plus address-change detection and the pending slot) in one sub-module, cart_strobe_detect, instantiated once per port.

Verification
REQ-029 Bench SHALL check: ROM word read at rom_addr=24'h008000, mem_rdata=16'hA55A with ack 2 cycles after req -> mem_addr=25'h0008000, mem_be=2'b11, rom_q=16'hA55A.
REQ-030 Bench SHALL check: ROM byte read at addr 24'h000001, mem_rdata=16'h12_34 -> mem_be=2'b10, rom_q=16'h1212.
REQ-031 Bench SHALL check: BSRAM write at addr 20'h00003, data 8'h7E -> mem_addr=25'h1000003, mem_we=1, mem_be=2'b10, mem_wdata=16'h7E7E.
REQ-032 Bench SHALL check: ROM and BSRAM reads detected in the same cycle -> ROM serviced first, then BSRAM, busy high throughout both.
REQ-033 Bench SHALL check: rom_addr changed 8000->8002 with CE/OE held low during an in-flight access -> second request issued after the first ack.
REQ-034 Bench SHALL check: rst_n pulsed low while mem_req=1 -> mem_req=0 immediately, and a late mem_ack leaves rom_q=0; with and without CART_ROM_WRITE_EN, rom_we_n low gives mem_we=1 or 0 respectively.

Source files
------------

// File: rtl/cart_mem_pkg.sv
// cart_mem_pkg: shared types and helpers for the cartridge memory responder.
// Contents: FSM state enum, in-flight port-select enum, default BSRAM window
// base address, and small byte-lane helpers used when building and
// completing backing-memory requests.
package cart_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROM_ACC = 2'd1,
    BS_ACC  = 2'd2
  } state_t;

  typedef enum logic {
    PSEL_ROM   = 1'b0,
    PSEL_BSRAM = 1'b1
  } port_sel_t;

  localparam logic [24:0] BSRAM_BASE_DEFAULT = 25'h1000000;

  // Byte lanes for a 16-bit backing word: odd byte lives in the upper lane.
  function automatic logic [1:0] byte_enables(input logic word, input logic a0);
    if (word) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] select_byte(input logic [15:0] d, input logic a0);
    return a0 ? d[15:8] : d[7:0];
  endfunction

endpackage

// File: rtl/cart_strobe_detect.sv
// cart_strobe_detect: access-start detection and one-deep pending slot for a
// single cartridge bus port.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_ce_n/i_oe_n/i_we_n    bus strobes (write strobe honoured only if WE_EN)
//   i_addr, i_data, i_word  access qualifiers latched at detection
//   i_take                  requester copied the slot into a memory request
//   i_clr                   the memory request for this port completed
//   o_pending, o_addr, o_data, o_word, o_write   slot contents
module cart_strobe_detect #(
  parameter int AW    = 24,
  parameter int DW    = 16,
  parameter bit WE_EN = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ce_n,
  input  logic          i_oe_n,
  input  logic          i_we_n,
  input  logic          i_word,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic          i_take,
  input  logic          i_clr,
  output logic          o_pending,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_word,
  output logic          o_write
);

  logic          w_write;
  logic          w_cond;
  logic          w_detect;
  logic          r_cond_d;
  logic [AW-1:0] r_addr_d;
  logic          r_pending;
  logic          r_newer;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_word;
  logic          r_write;

  assign w_write  = WE_EN && !i_we_n;
  assign w_cond   = !i_ce_n && (!i_oe_n || w_write);
  // A new access is either the strobe condition rising or the address
  // moving underneath a held strobe (burst-style host reads).
  assign w_detect = w_cond && (!r_cond_d || (i_addr != r_addr_d));

  // r_newer marks a detection made after the slot was last copied out, so a
  // completion must not throw that newer access away.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cond_d  <= 1'b0;
      r_addr_d  <= '0;
      r_pending <= 1'b0;
      r_newer   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_word    <= 1'b0;
      r_write   <= 1'b0;
    end else begin
      r_cond_d <= w_cond;
      r_addr_d <= i_addr;
      if (w_detect) begin
        r_pending <= 1'b1;
        r_newer   <= 1'b1;
        r_addr    <= i_addr;
        r_data    <= i_data;
        r_word    <= i_word;
        r_write   <= w_write;
      end else begin
        if (i_take) r_newer <= 1'b0;
        if (i_clr && !r_newer) r_pending <= 1'b0;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_addr    = r_addr;
  assign o_data    = r_data;
  assign o_word    = r_word;
  assign o_write   = r_write;

endmodule

// File: rtl/cart_mem_responder.sv
// cart_mem_responder: serves cartridge ROM and BSRAM bus accesses from a
// single shared backing memory with a req/ack handshake.
// Ports:
//   mclk, rst_n                          master clock, async active-low reset
//   rom_addr/rom_d/rom_ce_n/rom_oe_n/rom_we_n/rom_word, rom_q     ROM port
//   bsram_addr/bsram_d/bsram_ce_n/bsram_oe_n/bsram_we_n, bsram_q BSRAM port
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata, mem_ack/mem_rdata  backing memory
//   busy                                 access in flight or pending
// Build option: CART_ROM_WRITE_EN turns rom_we_n into a ROM write strobe
// (flash cartridges); without it every ROM access is a read.
module cart_mem_responder
  import cart_mem_pkg::*;
#(
  parameter logic [24:0] BSRAM_BASE = BSRAM_BASE_DEFAULT,
  parameter int          ROM_WIDTH  = 24
) (
  input  logic                 mclk,
  input  logic                 rst_n,
  input  logic [ROM_WIDTH-1:0] rom_addr,
  input  logic [15:0]          rom_d,
  input  logic                 rom_ce_n,
  input  logic                 rom_oe_n,
  input  logic                 rom_we_n,
  input  logic                 rom_word,
  output logic [15:0]          rom_q,
  input  logic [19:0]          bsram_addr,
  input  logic [7:0]           bsram_d,
  input  logic                 bsram_ce_n,
  input  logic                 bsram_oe_n,
  input  logic                 bsram_we_n,
  output logic [7:0]           bsram_q,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [24:0]          mem_addr,
  output logic [1:0]           mem_be,
  output logic [15:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic [15:0]          mem_rdata,
  output logic                 busy
);

`ifdef CART_ROM_WRITE_EN
  localparam bit ROM_WE_EN = 1'b1;
`else
  localparam bit ROM_WE_EN = 1'b0;
`endif

  state_t                 r_state;
  state_t                 w_state_nxt;
  port_sel_t              w_sel;
  logic                   r_mem_req;
  logic                   r_mem_we;
  logic [24:0]            r_mem_addr;
  logic [1:0]             r_mem_be;
  logic [15:0]            r_mem_wdata;
  logic [15:0]            r_rom_q;
  logic [7:0]             r_bsram_q;
  logic                   w_issue;
  logic                   w_ack;
  logic [7:0]             w_ack_byte;
  logic                   w_rom_pending;
  logic [ROM_WIDTH-1:0]   w_rom_addr;
  logic [15:0]            w_rom_data;
  logic                   w_rom_word;
  logic                   w_rom_write;
  logic                   w_bs_pending;
  logic [19:0]            w_bs_addr;
  logic [7:0]             w_bs_data;
  logic                   w_bs_word;
  logic                   w_bs_write;

  assign w_sel      = (r_state == BS_ACC) ? PSEL_BSRAM : PSEL_ROM;
  // The first cycle in an access state is the one with mem_req still low.
  assign w_issue    = (r_state != IDLE) && !r_mem_req;
  assign w_ack      = r_mem_req && mem_ack;
  assign w_ack_byte = select_byte(mem_rdata, r_mem_be == 2'b10);

  cart_strobe_detect #(
    .AW    (ROM_WIDTH),
    .DW    (16),
    .WE_EN (ROM_WE_EN)
  ) u_rom_det (
    .i_clk     (mclk),
    .i_rst_n   (rst_n),
    .i_ce_n    (rom_ce_n),
    .i_oe_n    (rom_oe_n),
    .i_we_n    (rom_we_n),
    .i_word    (rom_word),
    .i_addr    (rom_addr),
    .i_data    (rom_d),
    .i_take    (w_issue && (w_sel == PSEL_ROM)),
    .i_clr     (w_ack && (w_sel == PSEL_ROM)),
    .o_pending (w_rom_pending),
    .o_addr    (w_rom_addr),
    .o_data    (w_rom_data),
    .o_word    (w_rom_word),
    .o_write   (w_rom_write)
  );

  cart_strobe_detect #(
    .AW    (20),
    .DW    (8),
    .WE_EN (1'b1)
  ) u_bs_det (
    .i_clk     (mclk),
    .i_rst_n   (rst_n),
    .i_ce_n    (bsram_ce_n),
    .i_oe_n    (bsram_oe_n),
    .i_we_n    (bsram_we_n),
    .i_word    (1'b0),
    .i_addr    (bsram_addr),
    .i_data    (bsram_d),
    .i_take    (w_issue && (w_sel == PSEL_BSRAM)),
    .i_clr     (w_ack && (w_sel == PSEL_BSRAM)),
    .o_pending (w_bs_pending),
    .o_addr    (w_bs_addr),
    .o_data    (w_bs_data),
    .o_word    (w_bs_word),
    .o_write   (w_bs_write)
  );

  // State register.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Arbitration: ROM wins when both slots are pending; an access state is
  // held until the backing memory acknowledges.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_rom_pending)     w_state_nxt = ROM_ACC;
        else if (w_bs_pending) w_state_nxt = BS_ACC;
      end
      ROM_ACC, BS_ACC: begin
        if (w_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request launch copies the slot so later detections cannot disturb an
  // in-flight request; completion loads read data into the port's register.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_rom_q     <= '0;
      r_bsram_q   <= '0;
    end else if (w_issue) begin
      r_mem_req <= 1'b1;
      if (w_sel == PSEL_ROM) begin
        r_mem_we    <= w_rom_write;
        r_mem_addr  <= 25'(w_rom_addr);
        r_mem_be    <= byte_enables(w_rom_word, w_rom_addr[0]);
        r_mem_wdata <= w_rom_write ? (w_rom_word ? w_rom_data : {2{w_rom_data[7:0]}})
                                   : 16'h0000;
      end else begin
        r_mem_we    <= w_bs_write;
        r_mem_addr  <= BSRAM_BASE | 25'(w_bs_addr);
        r_mem_be    <= byte_enables(w_bs_word, w_bs_addr[0]);
        r_mem_wdata <= w_bs_write ? {2{w_bs_data}} : 16'h0000;
      end
    end else if (w_ack) begin
      r_mem_req <= 1'b0;
      if (!r_mem_we) begin
        if (w_sel == PSEL_ROM)
          r_rom_q <= (r_mem_be == 2'b11) ? mem_rdata : {2{w_ack_byte}};
        else
          r_bsram_q <= w_ack_byte;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
  assign rom_q     = r_rom_q;
  assign bsram_q   = r_bsram_q;
  assign busy      = (r_state != IDLE) || w_rom_pending || w_bs_pending;

endmodule

// File: tb/tb_cart_mem_responder.sv
// tb_cart_mem_responder: directed scenarios plus randomized ROM/BSRAM traffic
// checked against a simple arithmetic model of the expected memory requests
// and read-back values. Honours CART_ROM_WRITE_EN for the ROM write cases.
module tb_cart_mem_responder;

  logic        mclk = 1'b0;
  logic        rst_n;
  logic [23:0] rom_addr;
  logic [15:0] rom_d;
  logic        rom_ce_n, rom_oe_n, rom_we_n, rom_word;
  logic [15:0] rom_q;
  logic [19:0] bsram_addr;
  logic [7:0]  bsram_d;
  logic        bsram_ce_n, bsram_oe_n, bsram_we_n;
  logic [7:0]  bsram_q;
  logic        mem_req, mem_we;
  logic [24:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [24:0] obs_addr;
  logic [1:0]  obs_be;
  logic        obs_we;
  logic [15:0] obs_wdata;
  bit          obs_stable;
  bit          obs_req_dropped;
  bit          busy_seen_low;

  always #5 mclk = ~mclk;

  cart_mem_responder dut (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .rom_addr   (rom_addr),
    .rom_d      (rom_d),
    .rom_ce_n   (rom_ce_n),
    .rom_oe_n   (rom_oe_n),
    .rom_we_n   (rom_we_n),
    .rom_word   (rom_word),
    .rom_q      (rom_q),
    .bsram_addr (bsram_addr),
    .bsram_d    (bsram_d),
    .bsram_ce_n (bsram_ce_n),
    .bsram_oe_n (bsram_oe_n),
    .bsram_we_n (bsram_we_n),
    .bsram_q    (bsram_q),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  // Everything is driven and sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic wait_req(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 40) begin
      tick();
      cyc++;
      if (!busy) busy_seen_low = 1'b1;
      if (mem_req) ok = 1'b1;
    end
  endtask

  // Acts as the backing memory for one request: waits for mem_req, records
  // the request, acks after waitc cycles and notes whether req dropped.
  task automatic do_access(input int waitc, input logic [15:0] rdata,
                           output bit ok, output int cyc);
    wait_req(ok, cyc);
    obs_stable      = 1'b0;
    obs_req_dropped = 1'b0;
    if (ok) begin
      obs_addr  = mem_addr;
      obs_be    = mem_be;
      obs_we    = mem_we;
      obs_wdata = mem_wdata;
      for (int i = 0; i < waitc; i++) begin
        tick();
        if (!busy) busy_seen_low = 1'b1;
      end
      obs_stable = mem_req && (mem_addr === obs_addr) && (mem_be === obs_be) &&
                   (mem_we === obs_we) && (mem_wdata === obs_wdata);
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_ack = 1'b0;
      obs_req_dropped = !mem_req;
    end
  endtask

  task automatic release_bus();
    rom_ce_n   = 1'b1;
    rom_oe_n   = 1'b1;
    rom_we_n   = 1'b1;
    bsram_ce_n = 1'b1;
    bsram_oe_n = 1'b1;
    bsram_we_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== 45'h0)
      $display("[TB] FAIL reset_mem_outputs: got %h, expected 0",
               {mem_req, mem_we, mem_addr, mem_be, mem_wdata});
    else n_pass++;
    n_checks++;
    if ({rom_q, bsram_q} !== 24'h0)
      $display("[TB] FAIL reset_read_data: got %h, expected 0", {rom_q, bsram_q});
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", busy);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rom_word_read();
    bit ok;
    int cyc;
    rom_addr = 24'h008000;
    rom_word = 1'b1;
    rom_ce_n = 1'b0;
    rom_oe_n = 1'b0;
    do_access(2, 16'hA55A, ok, cyc);
    n_checks++;
    if (!ok) $display("[TB] FAIL word_req_timeout: got no mem_req, expected one within 40 cycles");
    else n_pass++;
    n_checks++;
    if (obs_addr !== 25'h0008000) $display("[TB] FAIL word_addr: got %h, expected 0008000", obs_addr);
    else n_pass++;
    n_checks++;
    if (obs_be !== 2'b11) $display("[TB] FAIL word_be: got %b, expected 11", obs_be);
    else n_pass++;
    n_checks++;
    if (obs_we !== 1'b0) $display("[TB] FAIL word_we: got %b, expected 0", obs_we);
    else n_pass++;
    n_checks++;
    if (!obs_stable) $display("[TB] FAIL word_req_stable: got unstable request, expected stable until ack");
    else n_pass++;
    n_checks++;
    if (!obs_req_dropped) $display("[TB] FAIL word_req_drop: got mem_req=1 after ack, expected 0");
    else n_pass++;
    n_checks++;
    if (rom_q !== 16'hA55A) $display("[TB] FAIL word_rom_q: got %h, expected a55a", rom_q);
    else n_pass++;
    release_bus();
    n_checks++;
    if (busy !== 1'b0) $display("[TB] FAIL word_idle_busy: got %b, expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_rom_byte_read();
    bit ok;
    int cyc;
    rom_addr = 24'h000001;
    rom_word = 1'b0;
    rom_ce_n = 1'b0;
    rom_oe_n = 1'b0;
    do_access(0, 16'h1234, ok, cyc);
    n_checks++;
    if (!ok || cyc != 3)
      $display("[TB] FAIL byte_req_latency: got ok=%0d after %0d cycles, expected req after 3", ok, cyc);
    else n_pass++;
    n_checks++;
    if (obs_be !== 2'b10) $display("[TB] FAIL byte_be: got %b, expected 10", obs_be);
    else n_pass++;
    n_checks++;
    if (rom_q !== 16'h1212) $display("[TB] FAIL byte_rom_q: got %h, expected 1212", rom_q);
    else n_pass++;
    release_bus();
  endtask

  task automatic test_bsram_write();
    bit ok;
    int cyc;
    bsram_addr = 20'h00003;
    bsram_d    = 8'h7E;
    bsram_ce_n = 1'b0;
    bsram_we_n = 1'b0;
    do_access(1, 16'hFFFF, ok, cyc);
    n_checks++;
    if (!ok || obs_addr !== 25'h1000003)
      $display("[TB] FAIL bs_wr_addr: got ok=%0d addr=%h, expected 1000003", ok, obs_addr);
    else n_pass++;
    n_checks++;
    if (obs_we !== 1'b1) $display("[TB] FAIL bs_wr_we: got %b, expected 1", obs_we);
    else n_pass++;
    n_checks++;
    if (obs_be !== 2'b10) $display("[TB] FAIL bs_wr_be: got %b, expected 10", obs_be);
    else n_pass++;
    n_checks++;
    if (obs_wdata !== 16'h7E7E) $display("[TB] FAIL bs_wr_wdata: got %h, expected 7e7e", obs_wdata);
    else n_pass++;
    n_checks++;
    if (bsram_q !== 8'h00 || rom_q !== 16'h1212)
      $display("[TB] FAIL bs_wr_hold_q: got bsram_q=%h rom_q=%h, expected 00 and 1212", bsram_q, rom_q);
    else n_pass++;
    release_bus();
  endtask

  task automatic test_simultaneous();
    bit ok;
    int cyc;
    rom_addr   = 24'h000010;
    rom_word   = 1'b1;
    bsram_addr = 20'h00020;
    busy_seen_low = 1'b0;
    rom_ce_n   = 1'b0;
    rom_oe_n   = 1'b0;
    bsram_ce_n = 1'b0;
    bsram_oe_n = 1'b0;
    do_access(1, 16'hC3D4, ok, cyc);
    n_checks++;
    if (!ok || obs_addr !== 25'h0000010)
      $display("[TB] FAIL simul_first_is_rom: got ok=%0d addr=%h, expected 0000010", ok, obs_addr);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("[TB] FAIL simul_busy_between: got %b, expected 1", busy);
    else n_pass++;
    do_access(0, 16'h9A8B, ok, cyc);
    n_checks++;
    if (!ok || obs_addr !== 25'h1000020)
      $display("[TB] FAIL simul_second_is_bsram: got ok=%0d addr=%h, expected 1000020", ok, obs_addr);
    else n_pass++;
    n_checks++;
    if (rom_q !== 16'hC3D4) $display("[TB] FAIL simul_rom_q: got %h, expected c3d4", rom_q);
    else n_pass++;
    n_checks++;
    if (bsram_q !== 8'h8B) $display("[TB] FAIL simul_bsram_q: got %h, expected 8b", bsram_q);
    else n_pass++;
    n_checks++;
    if (busy_seen_low) $display("[TB] FAIL simul_busy_throughout: got busy=0 mid-sequence, expected 1");
    else n_pass++;
    release_bus();
    n_checks++;
    if (busy !== 1'b0) $display("[TB] FAIL simul_idle_busy: got %b, expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_addr_change();
    bit ok;
    int cyc;
    rom_addr = 24'h008000;
    rom_word = 1'b1;
    rom_ce_n = 1'b0;
    rom_oe_n = 1'b0;
    wait_req(ok, cyc);
    n_checks++;
    if (!ok || mem_addr !== 25'h0008000)
      $display("[TB] FAIL chg_first_addr: got ok=%0d addr=%h, expected 0008000", ok, mem_addr);
    else n_pass++;
    rom_addr = 24'h008002;
    repeat (2) tick();
    n_checks++;
    if (mem_addr !== 25'h0008000) $display("[TB] FAIL chg_inflight_stable: got %h, expected 0008000", mem_addr);
    else n_pass++;
    mem_ack   = 1'b1;
    mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    n_checks++;
    if (rom_q !== 16'h1111) $display("[TB] FAIL chg_first_rom_q: got %h, expected 1111", rom_q);
    else n_pass++;
    do_access(0, 16'h2222, ok, cyc);
    n_checks++;
    if (!ok || obs_addr !== 25'h0008002)
      $display("[TB] FAIL chg_second_addr: got ok=%0d addr=%h, expected 0008002", ok, obs_addr);
    else n_pass++;
    n_checks++;
    if (rom_q !== 16'h2222) $display("[TB] FAIL chg_second_rom_q: got %h, expected 2222", rom_q);
    else n_pass++;
    release_bus();
    n_checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0)
      $display("[TB] FAIL chg_no_extra_req: got busy=%b req=%b, expected 0 0", busy, mem_req);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    int cyc;
    rom_addr = 24'h000100;
    rom_word = 1'b1;
    rom_ce_n = 1'b0;
    rom_oe_n = 1'b0;
    wait_req(ok, cyc);
    n_checks++;
    if (!ok) $display("[TB] FAIL rst_mid_req_timeout: got no mem_req, expected one");
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) $display("[TB] FAIL rst_mid_req_drop: got %b, expected 0", mem_req);
    else n_pass++;
    n_checks++;
    if (rom_q !== 16'h0000) $display("[TB] FAIL rst_mid_rom_q_clear: got %h, expected 0000", rom_q);
    else n_pass++;
    rom_ce_n = 1'b1;
    rom_oe_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    tick();
    n_checks++;
    if (rom_q !== 16'h0000) $display("[TB] FAIL rst_late_ack_rom_q: got %h, expected 0000", rom_q);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0)
      $display("[TB] FAIL rst_late_ack_idle: got busy=%b req=%b, expected 0 0", busy, mem_req);
    else n_pass++;
  endtask

  task automatic test_rom_write_cfg();
    bit          ok;
    int          cyc;
    logic        exp_we;
    logic [15:0] exp_q;
`ifdef CART_ROM_WRITE_EN
    exp_we = 1'b1;
    exp_q  = 16'h0000;
`else
    exp_we = 1'b0;
    exp_q  = 16'h0F0F;
`endif
    rom_addr = 24'h000200;
    rom_word = 1'b1;
    rom_d    = 16'h5AA5;
    rom_ce_n = 1'b0;
    rom_oe_n = 1'b0;
    rom_we_n = 1'b0;
    do_access(0, 16'h0F0F, ok, cyc);
    n_checks++;
    if (!ok) $display("[TB] FAIL romwr_req_timeout: got no mem_req, expected one");
    else n_pass++;
    n_checks++;
    if (obs_we !== exp_we) $display("[TB] FAIL romwr_mem_we: got %b, expected %b", obs_we, exp_we);
    else n_pass++;
    n_checks++;
    if (rom_q !== exp_q) $display("[TB] FAIL romwr_rom_q: got %h, expected %h", rom_q, exp_q);
    else n_pass++;
    release_bus();
  endtask

  // Random single accesses; the model derives each expected request and the
  // resulting read registers directly from the port/address/data rules.
  task automatic test_random_traffic();
    bit          ok, is_bs, wr, wd;
    int          cyc, wc;
    logic [23:0] a;
    logic [19:0] ba;
    logic [15:0] d, rd, e_wdata, m_rom_q;
    logic [7:0]  bd, m_bs_q;
    logic [24:0] e_addr;
    logic [1:0]  e_be;
`ifdef CART_ROM_WRITE_EN
    m_rom_q = 16'h0000;
`else
    m_rom_q = 16'h0F0F;
`endif
    m_bs_q = 8'h00;
    for (int it = 0; it < 24; it++) begin
      is_bs = 1'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      wc    = int'($urandom_range(0, 3));
      rd    = 16'($urandom);
      if (!is_bs) begin
        a  = 24'($urandom);
        wd = 1'($urandom_range(0, 1));
        d  = 16'($urandom);
        rom_addr = a;
        rom_word = wd;
        rom_d    = d;
`ifdef CART_ROM_WRITE_EN
        rom_oe_n = wr;
        rom_we_n = !wr;
`else
        wr       = 1'b0;
        rom_oe_n = 1'b0;
        rom_we_n = 1'($urandom_range(0, 1));
`endif
        rom_ce_n = 1'b0;
        e_addr   = 25'(a);
        e_be     = wd ? 2'd3 : ((a % 2 == 1) ? 2'd2 : 2'd1);
        e_wdata  = wd ? d : 16'((d % 256) * 257);
        if (!wr) m_rom_q = wd ? rd : 16'((((a % 2 == 1) ? (rd / 256) : (rd % 256))) * 257);
      end else begin
        ba = 20'($urandom);
        bd = 8'($urandom);
        bsram_addr = ba;
        bsram_d    = bd;
        bsram_oe_n = wr;
        bsram_we_n = !wr;
        bsram_ce_n = 1'b0;
        e_addr  = 25'h1000000 + 25'(ba);
        e_be    = (ba % 2 == 1) ? 2'd2 : 2'd1;
        e_wdata = 16'(bd * 257);
        if (!wr) m_bs_q = 8'((ba % 2 == 1) ? (rd / 256) : (rd % 256));
      end
      do_access(wc, rd, ok, cyc);
      n_checks++;
      if (!ok) $display("[TB] FAIL rnd%0d_req_timeout: got no mem_req, expected one", it);
      else n_pass++;
      n_checks++;
      if (obs_addr !== e_addr) $display("[TB] FAIL rnd%0d_addr: got %h, expected %h", it, obs_addr, e_addr);
      else n_pass++;
      n_checks++;
      if (obs_be !== e_be) $display("[TB] FAIL rnd%0d_be: got %b, expected %b", it, obs_be, e_be);
      else n_pass++;
      n_checks++;
      if (obs_we !== wr) $display("[TB] FAIL rnd%0d_we: got %b, expected %b", it, obs_we, wr);
      else n_pass++;
      if (wr) begin
        n_checks++;
        if (obs_wdata !== e_wdata)
          $display("[TB] FAIL rnd%0d_wdata: got %h, expected %h", it, obs_wdata, e_wdata);
        else n_pass++;
      end
      n_checks++;
      if (!obs_stable || !obs_req_dropped)
        $display("[TB] FAIL rnd%0d_handshake: got stable=%0d dropped=%0d, expected 1 1",
                 it, obs_stable, obs_req_dropped);
      else n_pass++;
      n_checks++;
      if (rom_q !== m_rom_q) $display("[TB] FAIL rnd%0d_rom_q: got %h, expected %h", it, rom_q, m_rom_q);
      else n_pass++;
      n_checks++;
      if (bsram_q !== m_bs_q) $display("[TB] FAIL rnd%0d_bsram_q: got %h, expected %h", it, bsram_q, m_bs_q);
      else n_pass++;
      release_bus();
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    rom_addr   = '0;
    rom_d      = '0;
    rom_ce_n   = 1'b1;
    rom_oe_n   = 1'b1;
    rom_we_n   = 1'b1;
    rom_word   = 1'b0;
    bsram_addr = '0;
    bsram_d    = '0;
    bsram_ce_n = 1'b1;
    bsram_oe_n = 1'b1;
    bsram_we_n = 1'b1;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    busy_seen_low = 1'b0;
    test_reset();
    test_rom_word_read();
    test_rom_byte_read();
    test_bsram_write();
    test_simultaneous();
    test_addr_change();
    test_reset_mid_access();
    test_rom_write_cfg();
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
